// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes instruction words into ALU controls and
// queues them in a 2-entry skid FIFO toward the execute stage.
module alu_issue #(
  parameter int OP_WIDTH    = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_WIDTH-1:0]    aluop,
  output logic                   alumux1_sel,
  output logic                   alumux2_sel,
  output logic [31:0]            imm,
  output logic [31:0]            pc,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] illegal_count
);

  localparam logic [OP_WIDTH-1:0] ALU_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_SUB   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALU_SLL   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALU_SLT   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALU_SLTU  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALU_XOR   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALU_SRL   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] ALU_SRA   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] ALU_OR    = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] ALU_AND   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] ALU_PASSB = OP_WIDTH'(10);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [OP_WIDTH-1:0] aluop;
    logic                mux1;
    logic                mux2;
    logic [31:0]         imm;
    logic [31:0]         pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
  } entry_t;

  // funct3 selects the operation; alt (funct7 bit 5) picks SUB/SRA
  function automatic logic [OP_WIDTH-1:0] op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  op_from_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op_from_f3 = ALU_SLL;
      3'b010:  op_from_f3 = ALU_SLT;
      3'b011:  op_from_f3 = ALU_SLTU;
      3'b100:  op_from_f3 = ALU_XOR;
      3'b101:  op_from_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op_from_f3 = ALU_OR;
      default: op_from_f3 = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        is_shift;
  entry_t      dec;

  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b    = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign imm_j    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
          dec.aluop = op_from_f3(f3, f7[5]);
        else
          dec.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7 only exists for shifts; other OP-IMM forms use those bits as immediate
        if (is_shift && !(f7 == 7'b0 || (f7 == F7_ALT && f3 == 3'b101))) begin
          dec.illegal = 1'b1;
        end else begin
          dec.aluop = op_from_f3(f3, is_shift && f7[5]);
          dec.mux2  = 1'b1;
          dec.imm   = is_shift ? {27'b0, in_instr[24:20]} : imm_i;
        end
      end
      OPC_LUI:    begin dec.aluop = ALU_PASSB; dec.mux2 = 1'b1; dec.imm = imm_u; end
      OPC_AUIPC:  begin dec.mux1 = 1'b1; dec.mux2 = 1'b1; dec.imm = imm_u; end
      OPC_LOAD:   begin dec.mux2 = 1'b1; dec.imm = imm_i; end
      OPC_STORE:  begin dec.mux2 = 1'b1; dec.imm = imm_s; end
      OPC_BRANCH: begin dec.aluop = ALU_SUB; dec.imm = imm_b; end
      OPC_JAL:    begin dec.mux1 = 1'b1; dec.mux2 = 1'b1; dec.imm = imm_j; end
      OPC_JALR:   begin dec.mux2 = 1'b1; dec.imm = imm_i; end
      default:    dec.illegal = 1'b1;
    endcase
  end

  entry_t                 mem_q [2];
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;
  logic                   push, pop;
  entry_t                 head;

  assign in_ready  = (count_q < 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // empty FIFO (including just after reset) presents all-zero head fields
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    count_d   = count_q + 2'(push) - 2'(pop);
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    ill_cnt_d = ill_cnt_q;
    if (pop && head.illegal && !(&ill_cnt_q))
      ill_cnt_d = ill_cnt_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign aluop         = head.aluop;
  assign alumux1_sel   = head.mux1;
  assign alumux2_sel   = head.mux2;
  assign imm           = head.imm;
  assign pc            = head.pc;
  assign rd            = head.rd;
  assign rs1           = head.rs1;
  assign rs2           = head.rs2;
  assign illegal       = head.illegal;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed test-plan steps plus randomized traffic
// compared against an arithmetic RV32I decode model and an expected-entry queue.
module tb_alu_issue;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_instr, in_pc, imm, pc;
  logic [3:0]    aluop;
  logic          alumux1_sel, alumux2_sel, illegal;
  logic [4:0]    rd, rs1, rs2;
  logic [CW-1:0] illegal_count;

  alu_issue #(.OP_WIDTH(4), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop(aluop), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .imm(imm), .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned aluop;
    bit          m1, m2, ill;
    logic [31:0] imm, pc;
    int unsigned rd, rs1, rs2;
  } exp_t;

  exp_t        q[$];
  int unsigned mcnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from instruction-set rules using plain integer arithmetic
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    int   ii, si, bi, ji;
    int unsigned base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int unsigned f3 = int'(w[14:12]);
    int unsigned f7 = int'(w[31:25]);
    bit shift;
    e = '{aluop: 0, m1: 0, m2: 0, ill: 0, imm: 0, pc: p,
          rd: int'(w[11:7]), rs1: int'(w[19:15]), rs2: int'(w[24:20])};
    ii = $signed(w) >>> 20;
    si = (ii & ~31) | int'(w[11:7]);
    bi = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    ji = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    shift = (f3 == 1) || (f3 == 5);
    case (w[6:0])
      7'b0110011:
        if (f7 == 0) e.aluop = base[f3];
        else if (f7 == 32 && f3 == 0) e.aluop = 1;
        else if (f7 == 32 && f3 == 5) e.aluop = 7;
        else e.ill = 1;
      7'b0010011:
        if (shift && !(f7 == 0 || (f7 == 32 && f3 == 5))) e.ill = 1;
        else begin
          e.m2 = 1;
          e.imm = shift ? 32'(w[24:20]) : 32'(ii);
          e.aluop = (f3 == 5 && f7 == 32) ? 7 : base[f3];
        end
      7'b0110111: begin e.aluop = 10; e.m2 = 1; e.imm = w & 32'hFFFFF000; end
      7'b0010111: begin e.m1 = 1; e.m2 = 1; e.imm = w & 32'hFFFFF000; end
      7'b0000011: begin e.m2 = 1; e.imm = 32'(ii); end
      7'b0100011: begin e.m2 = 1; e.imm = 32'(si); end
      7'b1100011: begin e.aluop = 1; e.imm = 32'(bi); end
      7'b1101111: begin e.m1 = 1; e.m2 = 1; e.imm = 32'(ji); end
      7'b1100111: begin e.m2 = 1; e.imm = 32'(ii); end
      default:    e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p, input logic r);
    in_valid = v; in_instr = w; in_pc = p; out_ready = r;
  endtask

  // Check outputs mid-cycle against the model, then advance model and DUT one edge
  task automatic tick();
    bit do_push, do_pop;
    #2;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2 && !rst));
    chk("illegal_count", 32'(illegal_count), mcnt);
    if (q.size() != 0) begin
      chk("aluop", 32'(aluop), q[0].aluop);
      chk("mux1", 32'(alumux1_sel), 32'(q[0].m1));
      chk("mux2", 32'(alumux2_sel), 32'(q[0].m2));
      chk("imm", imm, q[0].imm);
      chk("pc", pc, q[0].pc);
      chk("rd", 32'(rd), q[0].rd);
      chk("rs1", 32'(rs1), q[0].rs1);
      chk("rs2", 32'(rs2), q[0].rs2);
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    do_push = in_valid && !rst && q.size() < 2;
    do_pop  = out_ready && !rst && q.size() != 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (do_pop) begin
        if (q[0].ill && mcnt < (1 << CW) - 1) mcnt++;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(model(in_instr, in_pc));
    end
    #1;
  endtask

  logic [31:0] w;
  int unsigned opsel;
  logic [6:0]  legal_opc [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};

  initial begin
    mcnt = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(illegal_count), 0);
    rst = 1'b0;

    drive(1, 32'h002081B3, 32'h0, 1); tick();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_aluop", 32'(aluop), 0);
    chk("add_mux", {30'b0, alumux1_sel, alumux2_sel}, 0);
    chk("add_regs", {17'b0, rd, rs1, rs2}, {17'b0, 5'd3, 5'd1, 5'd2});
    chk("add_illegal", 32'(illegal), 0);

    drive(1, 32'h40335293, 32'h4, 1); tick();
    chk("srai_aluop", 32'(aluop), 7);
    chk("srai_mux2", 32'(alumux2_sel), 1);
    chk("srai_imm", imm, 32'h3);
    chk("srai_rd_rs1", {22'b0, rd, rs1}, {22'b0, 5'd5, 5'd6});

    drive(1, 32'h123453B7, 32'h8, 1); tick();
    chk("lui_aluop", 32'(aluop), 10);
    chk("lui_mux2", 32'(alumux2_sel), 1);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", 32'(rd), 7);

    drive(1, 32'h12345397, 32'h100, 1); tick();
    chk("auipc_mux1", 32'(alumux1_sel), 1);
    chk("auipc_aluop", 32'(aluop), 0);
    chk("auipc_pc", pc, 32'h100);
    drive(0, 0, 0, 1); tick();

    // backpressure: two accepted, third refused until drain begins
    drive(1, 32'h002081B3, 32'h200, 0); tick();
    drive(1, 32'h40335293, 32'h204, 0); tick();
    drive(1, 32'h123453B7, 32'h208, 0); #1;
    chk("bp_in_ready_full", 32'(in_ready), 0);
    tick();
    drive(1, 32'h123453B7, 32'h208, 1); tick();
    drive(1, 32'h123453B7, 32'h208, 1); tick();
    chk("bp_third_head", pc, 32'h208);
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h00A00093 + (i << 7), 32'h300 + 4 * i, 1); tick();
      chk("stream_valid", 32'(out_valid), 1);
    end
    drive(0, 0, 0, 1); tick();

    repeat (3) begin drive(1, 32'hFFFFFFFF, 32'h400, 1); tick(); end
    chk("ill_head", 32'(illegal), 1);
    chk("ill_aluop", 32'(aluop), 0);
    drive(1, 32'h402081B3, 32'h404, 1); tick();
    chk("ill_count3", 32'(illegal_count), 3);
    chk("sub_illegal", 32'(illegal), 0);
    chk("sub_aluop", 32'(aluop), 1);
    drive(1, 32'h402091B3, 32'h408, 1); tick();
    chk("f7_sll_illegal", 32'(illegal), 1);
    repeat (14) begin drive(1, 32'hFFFFFFFF, 32'h40C, 1); tick(); end
    drive(0, 0, 0, 1); tick();
    chk("ill_saturate", 32'(illegal_count), 15);

    // clear the counter before random traffic
    rst = 1'b1; drive(0, 0, 0, 0); tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      opsel = $urandom_range(0, 11);
      if (opsel < 9) w[6:0] = legal_opc[opsel];
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      drive(1'($urandom_range(0, 3) != 0), w, $urandom, 1'($urandom_range(0, 2) != 0));
      tick();
    end

    // reset with the FIFO full: held entries must vanish
    drive(1, 32'h002081B3, 32'h500, 0); tick();
    drive(1, 32'h002081B3, 32'h504, 0); tick();
    drive(1, 32'hFFFFFFFF, 32'h508, 0);
    if (out_valid === 1'b1 && in_ready === 1'b0) begin
      drive(1, 32'hFFFFFFFF, 32'h508, 1); tick();
    end
    drive(1, 32'h002081B3, 32'h600, 0); tick();
    drive(1, 32'h002081B3, 32'h604, 0); tick();
    rst = 1'b1; drive(1, 32'h002081B3, 32'h608, 1); #1;
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_count", 32'(illegal_count), 0);
    chk("rst_mid_zero_head", {aluop, 4'b0, rd, rs1, rs2, 8'b0}, 0);
    chk("rst_mid_pc", pc, 0);
    drive(0, 0, 0, 1); #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    repeat (3) begin tick(); chk("post_rst_empty", 32'(out_valid), 0); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that produces the ALU's control inputs: opcode select, operand-mux selects and immediate.
- Accepts RV32I instruction words over a valid/ready handshake.
- Decodes them into the aluop and operand-mux selects consumed by alu.
- Buffers decoded entries in a 2-entry skid FIFO so execute-stage stalls never drop or duplicate an instruction.

Parameters:
OP_WIDTH, 4, width of aluop; must match alu
COUNT_WIDTH, 16, width of the saturating illegal-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_instr/in_pc valid
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  RV32I instruction word
in_pc  input  32  PC of in_instr
out_valid  output  1  decoded entry at head is valid
out_ready  input  1  execute stage consumes head this cycle
aluop  output  OP_WIDTH  ALU operation for alu
alumux1_sel  output  1  0 = rs1 value, 1 = PC
alumux2_sel  output  1  0 = rs2 value, 1 = imm
imm  output  32  sign-extended immediate
pc  output  32  PC of head entry
rd, rs1, rs2  output  5 each  register indices from instruction
illegal  output  1  head entry is an unsupported encoding
illegal_count  output  COUNT_WIDTH  saturating count of illegal entries issued

Behaviour:
- aluop encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Codes 11-15 are reserved and never emitted.
- Decode is combinational on in_instr. The result is written into the FIFO on input handshake (in_valid & in_ready).
- Decode by opcode:
  - OP (0110011): rs1/rs2 operands; funct3/funct7 select aluop.
  - OP-IMM (0010011): rs1/imm, I-type immediate. Shift immediate = zero-extended shamt [24:20].
  - LUI (0110111): PASSB with U-immediate.
  - AUIPC (0010111): PC + U-immediate (mux1=1, mux2=1).
  - LOAD: ADD rs1 + I-immediate.
  - STORE: ADD rs1 + S-immediate.
  - BRANCH: SUB rs1 - rs2; imm = B-immediate.
  - JAL: ADD PC + J-immediate.
  - JALR: ADD rs1 + I-immediate.
- funct7 legality: must be 0000000, except 0100000 with funct3 000 (SUB, OP only) or 101 (SRA/SRAI). Any other funct7 value is illegal.
- Any other opcode, or illegal funct7, gives illegal=1, aluop=ADD, mux selects 0, imm 0. The entry still flows through the FIFO.
- FIFO depth 2, occupancy 0..2:
  - in_ready = (occupancy < 2) & !rst.
  - out_valid = (occupancy != 0).
  - Head outputs are driven from registers and are stable while out_valid & !out_ready.
- Latency: an instruction accepted in cycle N appears at the head in cycle N+1 when the FIFO was empty. No combinational path from in_* to out_*.
- Simultaneous push and pop:
  - At occupancy 1: occupancy stays 1 and the new entry becomes head next cycle.
  - At occupancy 2: in_ready is 0, so no push occurs.
- Pointers wrap modulo 2.
- illegal_count increments on an output handshake whose head has illegal=1. It saturates at all-ones and does not wrap.
- Reset, including mid-operation: occupancy 0, out_valid 0, all head outputs 0, illegal_count 0, in_ready 0 during the reset cycle. Entries held at reset are discarded. in_ready = 1 on the first cycle after rst deasserts.

Test Plan:
- Basic ADD: in_instr 0x002081B3, out_ready=1 -> next cycle out_valid=1, aluop=0, alumux1_sel=0, alumux2_sel=0, rd=3, rs1=1, rs2=2, illegal=0.
- SRAI: in_instr 0x40335293 -> aluop=7, alumux2_sel=1, imm=0x00000003, rd=5, rs1=6.
- LUI: in_instr 0x123453B7 -> aluop=10, alumux2_sel=1, imm=0x12345000, rd=7. AUIPC with the same immediate and in_pc=0x100 -> alumux1_sel=1, aluop=0, pc=0x100.
- Backpressure: out_ready=0, present 3 consecutive valid instructions -> first two accepted, in_ready=0 on the third. Then raise out_ready -> outputs drain in order with no loss or duplication. Simultaneous push/pop at occupancy 1 keeps throughput 1 per cycle.
- Illegal handling:
  - in_instr 0xFFFFFFFF issued 3 times -> illegal=1, aluop=0, illegal_count=3.
  - 0x402081B3 (SUB) -> illegal=0, aluop=1.
  - 0x402091B3 (funct7 0100000, funct3 001) -> illegal=1.
  - Forced counter at max stays at max.
- Reset mid-operation: with occupancy 2, assert rst for one cycle -> out_valid=0, illegal_count=0, in_ready=0 that cycle, in_ready=1 the next. Held entries never appear at the output.
